// File: rtl/led_matrix_scanner.sv
// Row-scanned LED matrix driver: linear per-row PWM, second-half-slot blanking,
// and a valid/ready shadow frame buffer swapped into the display at frame boundaries.
module led_matrix_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 8,
    parameter int SLOT_LOG2      = 11,
    parameter int PWM_BITS       = 3,
    parameter int ROW_ACTIVE_LOW = 1,
    parameter int COL_ACTIVE_LOW = 1
) (
    input  logic                   clk12MHz,
    input  logic                   resetn,
    input  logic                   enable,
    input  logic [PWM_BITS-1:0]    brightness,
    input  logic [ROWS*COLS-1:0]   frame_data,
    input  logic                   frame_valid,
    output logic                   frame_ready,
    output logic                   frame_start,
    output logic [ROWS-1:0]        row_sel,
    output logic [COLS-1:0]        col_drv
);
    localparam int RW    = $clog2(ROWS);
    localparam int SHIFT = SLOT_LOG2 - 1 - PWM_BITS;
    localparam logic [ROWS-1:0] ROW_OFF  = (ROW_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [COLS-1:0] COL_OFF  = (COL_ACTIVE_LOW != 0) ? '1 : '0;
    localparam logic [RW-1:0]   LAST_ROW = RW'(ROWS - 1);

    logic [SLOT_LOG2-1:0]  slot_q, slot_d;
    logic [RW-1:0]         row_q, row_d;
    logic [ROWS*COLS-1:0]  disp_q, disp_d;
    logic [ROWS*COLS-1:0]  shadow_q, shadow_d;
    logic                  shadow_full_q, shadow_full_d;
    logic                  ready_q, ready_d;
    logic [COLS-1:0]       col_q, col_d;
    logic [PWM_BITS-1:0]   bri_q, bri_d;
    logic [ROWS-1:0]       row_sel_q, row_sel_d;
    logic [COLS-1:0]       col_drv_q, col_drv_d;
    logic                  start_q, start_d;

    logic                  slot_start;
    logic                  frame_end;
    logic                  on;
    logic [COLS-1:0]       row_bits;
    logic [ROWS-1:0]       row_onehot;
    logic [COLS-1:0]       col_eff;
    logic [PWM_BITS-1:0]   bri_eff;
    logic [SLOT_LOG2-1:0]  on_limit;

    always_comb begin
        slot_start = (slot_q == '0);
        frame_end  = (slot_q == '1) && (row_q == LAST_ROW);

        row_bits   = '0;
        row_onehot = '0;
        for (int unsigned r = 0; r < ROWS; r++) begin
            if (row_q == RW'(r)) begin
                row_bits      = disp_q[r*COLS +: COLS];
                row_onehot[r] = 1'b1;
            end
        end

        // In the first cycle of a slot the values being latched are used directly,
        // so every slot gets exactly bri<<SHIFT lit cycles.
        bri_eff  = slot_start ? brightness : bri_q;
        col_eff  = slot_start ? row_bits : col_q;
        on_limit = SLOT_LOG2'(bri_eff) << SHIFT;
        on       = enable && (slot_q < on_limit);

        slot_d        = slot_q;
        row_d         = row_q;
        col_d         = col_q;
        bri_d         = bri_q;
        disp_d        = disp_q;
        shadow_d      = shadow_q;
        shadow_full_d = shadow_full_q;

        if (enable) begin
            slot_d = slot_q + SLOT_LOG2'(1);
            if (slot_q == '1) begin
                row_d = (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
            end
            if (slot_start) begin
                col_d = row_bits;
                bri_d = brightness;
            end
            if (frame_end && shadow_full_q) begin
                disp_d        = shadow_q;
                shadow_full_d = 1'b0;
            end
        end

        // Accept and swap are mutually exclusive: accept needs an empty shadow, swap a full one.
        if (frame_valid && ready_q) begin
            shadow_d      = frame_data;
            shadow_full_d = 1'b1;
        end
        ready_d = ~shadow_full_d;

        row_sel_d = on ? (row_onehot ^ ROW_OFF) : ROW_OFF;
        col_drv_d = on ? (col_eff ^ COL_OFF) : COL_OFF;
        start_d   = enable && slot_start && (row_q == '0);
    end

    always_ff @(posedge clk12MHz or negedge resetn) begin
        if (!resetn) begin
            slot_q        <= '0;
            row_q         <= '0;
            disp_q        <= '0;
            shadow_q      <= '0;
            shadow_full_q <= 1'b0;
            ready_q       <= 1'b1;
            col_q         <= '0;
            bri_q         <= '0;
            row_sel_q     <= ROW_OFF;
            col_drv_q     <= COL_OFF;
            start_q       <= 1'b0;
        end else begin
            slot_q        <= slot_d;
            row_q         <= row_d;
            disp_q        <= disp_d;
            shadow_q      <= shadow_d;
            shadow_full_q <= shadow_full_d;
            ready_q       <= ready_d;
            col_q         <= col_d;
            bri_q         <= bri_d;
            row_sel_q     <= row_sel_d;
            col_drv_q     <= col_drv_d;
            start_q       <= start_d;
        end
    end

    assign frame_ready = ready_q;
    assign frame_start = start_q;
    assign row_sel     = row_sel_q;
    assign col_drv     = col_drv_q;

endmodule

// File: tb/tb_led_matrix_scanner.sv
// Directed bench for led_matrix_scanner: a 4-row and a 3-row instance, both with 64-clock slots.
module tb_led_matrix_scanner;
    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    logic        en_a, fv_a, fr_a, fs_a;
    logic [2:0]  bri_a;
    logic [31:0] fd_a;
    logic [3:0]  rs_a;
    logic [7:0]  cd_a;

    logic        en_b, fv_b, fr_b, fs_b;
    logic [2:0]  bri_b;
    logic [23:0] fd_b;
    logic [2:0]  rs_b;
    logic [7:0]  cd_b;

    int vectors = 0;
    int miscompares = 0;

    localparam logic [31:0] FA = {8'h18, 8'h24, 8'h42, 8'h81};
    localparam logic [31:0] FB = {8'hF0, 8'h0F, 8'hCC, 8'h33};
    localparam logic [31:0] FC = {8'hA5, 8'h5A, 8'h3C, 8'hC3};

    led_matrix_scanner #(
        .ROWS(4), .COLS(8), .SLOT_LOG2(6), .PWM_BITS(3), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
    ) dut (
        .clk12MHz(clk), .resetn(resetn), .enable(en_a), .brightness(bri_a),
        .frame_data(fd_a), .frame_valid(fv_a), .frame_ready(fr_a), .frame_start(fs_a),
        .row_sel(rs_a), .col_drv(cd_a)
    );

    led_matrix_scanner #(
        .ROWS(3), .COLS(8), .SLOT_LOG2(6), .PWM_BITS(3), .ROW_ACTIVE_LOW(1), .COL_ACTIVE_LOW(1)
    ) dut3 (
        .clk12MHz(clk), .resetn(resetn), .enable(en_b), .brightness(bri_b),
        .frame_data(fd_b), .frame_valid(fv_b), .frame_ready(fr_b), .frame_start(fs_b),
        .row_sel(rs_b), .col_drv(cd_b)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic do_reset;
        resetn = 1'b0;
        en_a = 1'b0; en_b = 1'b0; fv_a = 1'b0; fv_b = 1'b0;
        bri_a = 3'd0; bri_b = 3'd0; fd_a = '0; fd_b = '0;
        tick();
        tick();
        resetn = 1'b1;
    endtask

    task automatic count_active(input int n, output int cnt);
        cnt = 0;
        for (int i = 0; i < n; i++) begin
            tick();
            if (rs_a != 4'hF) cnt++;
        end
    endtask

    // Edge n after reset release shows counter state slot=(n-1)%64, row=((n-1)/64)%ROWS.
    task automatic test_reset;
        do_reset();
        vectors++; if (rs_a !== 4'hF) begin miscompares++; $display("FAIL rst_row_sel: got %h expected %h", rs_a, 4'hF); end
        vectors++; if (cd_a !== 8'hFF) begin miscompares++; $display("FAIL rst_col_drv: got %h expected %h", cd_a, 8'hFF); end
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL rst_ready: got %b expected 1", fr_a); end
        vectors++; if (fs_a !== 1'b0) begin miscompares++; $display("FAIL rst_start: got %b expected 0", fs_a); end
        bri_a = 3'd7; en_a = 1'b1; fd_a = FA; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        vectors++; if (fs_a !== 1'b1) begin miscompares++; $display("FAIL first_start: got %b expected 1", fs_a); end
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL first_accept_ready: got %b expected 0", fr_a); end
        run(258);
        vectors++; if (rs_a !== 4'b1110) begin miscompares++; $display("FAIL pre_rst_row: got %h expected %h", rs_a, 4'b1110); end
        vectors++; if (cd_a !== 8'h7E) begin miscompares++; $display("FAIL pre_rst_col: got %h expected %h", cd_a, 8'h7E); end
        fd_a = FB; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        #2 resetn = 1'b0;
        #1;
        vectors++; if (rs_a !== 4'hF) begin miscompares++; $display("FAIL midrst_row: got %h expected %h", rs_a, 4'hF); end
        vectors++; if (cd_a !== 8'hFF) begin miscompares++; $display("FAIL midrst_col: got %h expected %h", cd_a, 8'hFF); end
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL midrst_ready: got %b expected 1", fr_a); end
        vectors++; if (fs_a !== 1'b0) begin miscompares++; $display("FAIL midrst_start: got %b expected 0", fs_a); end
        tick();
        resetn = 1'b1;
        run(257);
        vectors++; if (rs_a !== 4'b1110) begin miscompares++; $display("FAIL post_rst_row: got %h expected %h", rs_a, 4'b1110); end
        vectors++; if (cd_a !== 8'hFF) begin miscompares++; $display("FAIL post_rst_discard: got %h expected %h", cd_a, 8'hFF); end
    endtask

    task automatic test_handshake;
        do_reset();
        bri_a = 3'd7; en_a = 1'b1; fd_a = FA; fv_a = 1'b1;
        tick();
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL hs_ready_after_a: got %b expected 0", fr_a); end
        fd_a = FB;
        run(254);
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL hs_b_stalled: got %b expected 0", fr_a); end
        tick();
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL hs_ready_after_swap: got %b expected 1", fr_a); end
        tick();
        fv_a = 1'b0;
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL hs_b_accepted: got %b expected 0", fr_a); end
        vectors++; if (rs_a !== 4'b1110) begin miscompares++; $display("FAIL hs_row0_sel: got %h expected %h", rs_a, 4'b1110); end
        vectors++; if (cd_a !== 8'h7E) begin miscompares++; $display("FAIL hs_row0_a: got %h expected %h", cd_a, 8'h7E); end
        vectors++; if (fs_a !== 1'b1) begin miscompares++; $display("FAIL hs_frame_start: got %b expected 1", fs_a); end
        run(255);
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL hs_ready_after_b_swap: got %b expected 1", fr_a); end
        tick();
        vectors++; if (cd_a !== 8'hCC) begin miscompares++; $display("FAIL hs_row0_b: got %h expected %h", cd_a, 8'hCC); end
    endtask

    task automatic test_brightness;
        int cnt, cnt2;
        do_reset();
        bri_a = 3'd5; en_a = 1'b1; fd_a = '1; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        run(255);
        count_active(64, cnt);
        vectors++; if (cnt !== 20) begin miscompares++; $display("FAIL bri5_on_cycles: got %0d expected 20", cnt); end
        bri_a = 3'd0;
        count_active(64, cnt);
        vectors++; if (cnt !== 0) begin miscompares++; $display("FAIL bri0_on_cycles: got %0d expected 0", cnt); end
        bri_a = 3'd7;
        count_active(10, cnt);
        bri_a = 3'd1;
        count_active(54, cnt2);
        vectors++; if (cnt + cnt2 !== 28) begin miscompares++; $display("FAIL bri7_midslot_change: got %0d expected 28", cnt + cnt2); end
        count_active(64, cnt);
        vectors++; if (cnt !== 4) begin miscompares++; $display("FAIL bri1_next_slot: got %0d expected 4", cnt); end
    endtask

    task automatic test_scan_order;
        int starts, nord, slot, row, idx;
        int order[4];
        logic [2:0] rs_exp;
        logic [7:0] cd_exp;
        do_reset();
        en_b = 1'b1; bri_b = 3'd7; fd_b = {8'h44, 8'h22, 8'h11}; fv_b = 1'b1;
        tick();
        fv_b = 1'b0;
        run(191);
        starts = 0;
        nord = 0;
        for (int i = 0; i < 256; i++) begin
            tick();
            slot = i % 64;
            row = (i / 64) % 3;
            rs_exp = 3'b111;
            cd_exp = 8'hFF;
            if (slot < 28) begin
                rs_exp[row] = 1'b0;
                cd_exp = ~fd_b[row*8 +: 8];
            end
            vectors++; if (rs_b !== rs_exp) begin miscompares++; $display("FAIL scan_row_sel[%0d]: got %b expected %b", i, rs_b, rs_exp); end
            vectors++; if (cd_b !== cd_exp) begin miscompares++; $display("FAIL scan_col_drv[%0d]: got %h expected %h", i, cd_b, cd_exp); end
            vectors++; if ($countones(~rs_b) > 1) begin miscompares++; $display("FAIL scan_onehot[%0d]: got %b expected at most one low", i, rs_b); end
            if (i < 192 && fs_b === 1'b1) starts++;
            if (slot == 0 && nord < 4) begin
                idx = -1;
                for (int r = 0; r < 3; r++) if (rs_b[r] === 1'b0) idx = r;
                order[nord] = idx;
                nord++;
            end
        end
        vectors++; if (order[0] !== 0) begin miscompares++; $display("FAIL scan_order0: got %0d expected 0", order[0]); end
        vectors++; if (order[1] !== 1) begin miscompares++; $display("FAIL scan_order1: got %0d expected 1", order[1]); end
        vectors++; if (order[2] !== 2) begin miscompares++; $display("FAIL scan_order2: got %0d expected 2", order[2]); end
        vectors++; if (order[3] !== 0) begin miscompares++; $display("FAIL scan_order3: got %0d expected 0", order[3]); end
        vectors++; if (starts !== 1) begin miscompares++; $display("FAIL scan_starts_per_192: got %0d expected 1", starts); end
    endtask

    task automatic test_tearing;
        do_reset();
        bri_a = 3'd7; en_a = 1'b1; fd_a = FA; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        run(399);
        fd_a = FB; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        vectors++; if (rs_a !== 4'b1011) begin miscompares++; $display("FAIL tear_row2_sel: got %h expected %h", rs_a, 4'b1011); end
        vectors++; if (cd_a !== 8'hDB) begin miscompares++; $display("FAIL tear_row2_old: got %h expected %h", cd_a, 8'hDB); end
        run(48);
        vectors++; if (rs_a !== 4'b0111) begin miscompares++; $display("FAIL tear_row3_sel: got %h expected %h", rs_a, 4'b0111); end
        vectors++; if (cd_a !== 8'hE7) begin miscompares++; $display("FAIL tear_row3_old: got %h expected %h", cd_a, 8'hE7); end
        run(63);
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL tear_ready: got %b expected 1", fr_a); end
        tick();
        vectors++; if (cd_a !== 8'hCC) begin miscompares++; $display("FAIL tear_row0_new: got %h expected %h", cd_a, 8'hCC); end
        run(254);
        fd_a = FC; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL edge_accept_ready: got %b expected 0", fr_a); end
        tick();
        vectors++; if (cd_a !== 8'hCC) begin miscompares++; $display("FAIL edge_accept_not_swapped: got %h expected %h", cd_a, 8'hCC); end
        run(255);
        vectors++; if (fr_a !== 1'b1) begin miscompares++; $display("FAIL edge_accept_ready_back: got %b expected 1", fr_a); end
        tick();
        vectors++; if (cd_a !== 8'h3C) begin miscompares++; $display("FAIL edge_accept_swapped: got %h expected %h", cd_a, 8'h3C); end
    endtask

    task automatic test_enable;
        do_reset();
        bri_a = 3'd7; en_a = 1'b1; fd_a = FA; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        run(259);
        vectors++; if (cd_a !== 8'h7E) begin miscompares++; $display("FAIL en_before_col: got %h expected %h", cd_a, 8'h7E); end
        en_a = 1'b0;
        tick();
        vectors++; if (rs_a !== 4'hF) begin miscompares++; $display("FAIL en_off_row: got %h expected %h", rs_a, 4'hF); end
        vectors++; if (cd_a !== 8'hFF) begin miscompares++; $display("FAIL en_off_col: got %h expected %h", cd_a, 8'hFF); end
        fd_a = FB; fv_a = 1'b1;
        tick();
        fv_a = 1'b0;
        vectors++; if (fr_a !== 1'b0) begin miscompares++; $display("FAIL en_off_accept: got %b expected 0", fr_a); end
        run(8);
        vectors++; if (rs_a !== 4'hF) begin miscompares++; $display("FAIL en_off_row_held: got %h expected %h", rs_a, 4'hF); end
        en_a = 1'b1;
        tick();
        vectors++; if (rs_a !== 4'b1110) begin miscompares++; $display("FAIL en_resume_row: got %h expected %h", rs_a, 4'b1110); end
        vectors++; if (cd_a !== 8'h7E) begin miscompares++; $display("FAIL en_resume_col: got %h expected %h", cd_a, 8'h7E); end
        run(59);
        vectors++; if (rs_a !== 4'hF) begin miscompares++; $display("FAIL en_slot_tail: got %h expected %h", rs_a, 4'hF); end
        tick();
        vectors++; if (rs_a !== 4'b1101) begin miscompares++; $display("FAIL en_next_row: got %h expected %h", rs_a, 4'b1101); end
        vectors++; if (cd_a !== 8'hBD) begin miscompares++; $display("FAIL en_next_row_col: got %h expected %h", cd_a, 8'hBD); end
    endtask

    initial begin
        test_reset();
        test_handshake();
        test_brightness();
        test_scan_order();
        test_tearing();
        test_enable();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end
endmodule
